// File: rtl/ddr_burst_rd_master_if.sv
`default_nettype none
//==============================================================================
// Module      : ddr_burst_rd_master_if
// Description : Bundle of the command, DDR burst-read and return-stream signals
//               of ddr_burst_rd_master.
//               master modport = the burst-read master itself,
//               slave  modport = its environment (command source, DDR
//               controller and stream consumer seen as one peer).
// Signals     : cmd_valid/cmd_ready/cmd_addr/cmd_beats  command handshake
//               burst_read_req/addr/len                 burst request
//               burst_read_data/valid/finish            returned beats
//               m_data/m_valid/m_ready                  output stream
//               busy/done                               status
//               err                                     beat-check flag, only
//                                                       with DDR_RD_BEATCHK_EN
// Revision    : 1.0  initial release
//==============================================================================

// Platform widths normally come from hyper_para.v; fall back to 64-bit data,
// 32-bit byte addresses and an 8-bit burst length field.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 8
`endif

interface ddr_burst_rd_master_if #(
  parameter int CNT_WIDTH = 24
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [`ADDR_SIZE-1:0]  cmd_addr;
  logic [CNT_WIDTH-1:0]   cmd_beats;
  logic                   burst_read_req;
  logic [`ADDR_SIZE-1:0]  burst_read_addr;
  logic [`LEN_WIDTH-1:0]  burst_read_len;
  logic [`DATA_WIDTH-1:0] burst_read_data;
  logic                   burst_read_valid;
  logic                   burst_read_finish;
  logic [`DATA_WIDTH-1:0] m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   busy;
  logic                   done;
`ifdef DDR_RD_BEATCHK_EN
  logic                   err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_beats,
    input  burst_read_data, burst_read_valid, burst_read_finish, m_ready,
    output cmd_ready, burst_read_req, burst_read_addr, burst_read_len,
    output m_data, m_valid, busy, done, err
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_beats,
    output burst_read_data, burst_read_valid, burst_read_finish, m_ready,
    input  cmd_ready, burst_read_req, burst_read_addr, burst_read_len,
    input  m_data, m_valid, busy, done, err
  );
`else
  modport master (
    input  cmd_valid, cmd_addr, cmd_beats,
    input  burst_read_data, burst_read_valid, burst_read_finish, m_ready,
    output cmd_ready, burst_read_req, burst_read_addr, burst_read_len,
    output m_data, m_valid, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_beats,
    output burst_read_data, burst_read_valid, burst_read_finish, m_ready,
    input  cmd_ready, burst_read_req, burst_read_addr, burst_read_len,
    input  m_data, m_valid, busy, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/ddr_burst_rd_master.sv
`default_nettype none
//==============================================================================
// Module      : ddr_burst_rd_master
// Description : DDR user burst-read initiator. Takes one command (byte base
//               address + beat count), splits it into bursts of at most
//               MAX_BURST beats, and buffers returned beats in a show-ahead
//               FIFO exposed as a valid/ready stream. A burst is requested
//               only when the FIFO can hold all of it, since the DDR side
//               cannot be stalled.
// Ports       : user_clk    clock
//               user_rst_n  asynchronous active-low reset
//               bus         ddr_burst_rd_master_if.master (command, burst
//                           request, returned beats, stream, busy/done[/err])
// Options     : DDR_RD_BEATCHK_EN  adds a per-burst beat counter and the
//                                  sticky bus.err flag
// Revision    : 1.0  initial release
//==============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 8
`endif

module ddr_burst_rd_master #(
  parameter int MAX_BURST  = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int CNT_WIDTH  = 24
) (
  input  wire logic                 user_clk,
  input  wire logic                 user_rst_n,
  ddr_burst_rd_master_if.master     bus
);

  localparam int AW    = `ADDR_SIZE;
  localparam int DW    = `DATA_WIDTH;
  localparam int LW    = `LEN_WIDTH;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BYTES = DW / 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]           state_q,    state_d;
  logic [AW-1:0]        cur_addr_q, cur_addr_d;
  logic [CNT_WIDTH-1:0] remain_q,   remain_d;
  logic [AW-1:0]        rd_addr_q,  rd_addr_d;
  logic [LW-1:0]        rd_len_q,   rd_len_d;
  logic                 req_q,      req_d;

  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;

  logic [LW-1:0]        calc_len;
  logic [CW-1:0]        free;
  logic [CNT_WIDTH-1:0] remain_after;

  assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
  // Beats offered while full are dropped; the CALC space check keeps this
  // from happening with a well-behaved controller.
  assign push         = bus.burst_read_valid && !fifo_full;
  assign pop          = (count_q != '0) && bus.m_ready;
  assign calc_len     = (remain_q < CNT_WIDTH'(MAX_BURST)) ? LW'(remain_q) : LW'(MAX_BURST);
  assign free         = CW'(FIFO_DEPTH) - count_q;
  assign remain_after = remain_q - CNT_WIDTH'(rd_len_q);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    req_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cur_addr_d = bus.cmd_addr;
          remain_d   = bus.cmd_beats;
          state_d    = (bus.cmd_beats == '0) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        // Wait here until the whole burst fits; the FIFO only drains meanwhile.
        if (32'(free) >= 32'(calc_len)) begin
          rd_addr_d = cur_addr_q;
          rd_len_d  = calc_len;
          req_d     = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.burst_read_finish) begin
          remain_d   = remain_after;
          cur_addr_d = cur_addr_q + AW'(rd_len_q) * AW'(BYTES);
          state_d    = (remain_after == '0) ? S_FIN : S_CALC;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      req_q      <= req_d;
    end
  end

  // Return-data FIFO storage; contents need no reset, pointers and count do.
  always_ff @(posedge user_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.burst_read_data;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.cmd_ready       = (state_q == S_IDLE);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = (state_q == S_FIN);
  assign bus.burst_read_req  = req_q;
  assign bus.burst_read_addr = rd_addr_q;
  assign bus.burst_read_len  = rd_len_q;
  assign bus.m_valid         = (count_q != '0);
  // Force zero when empty so the stream output is defined out of reset.
  assign bus.m_data          = (count_q != '0) ? mem[rd_ptr_q] : '0;

`ifdef DDR_RD_BEATCHK_EN
  localparam int LW1 = LW + 1;

  logic [LW1-1:0] beat_cnt_q;
  logic [LW1-1:0] beats_seen;
  logic           len_bad;
  logic           stray_beat;
  logic           err_q;

  // Count includes a beat that coincides with the finish pulse.
  assign beats_seen = beat_cnt_q + LW1'(bus.burst_read_valid);
  assign len_bad    = (state_q == S_WAIT) && bus.burst_read_finish &&
                      (beats_seen != {1'b0, rd_len_q});
  assign stray_beat = bus.burst_read_valid &&
                      (fifo_full || state_q == S_IDLE || state_q == S_CALC || state_q == S_FIN);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (req_d || ((state_q == S_WAIT) && bus.burst_read_finish)) begin
        beat_cnt_q <= '0;
      end else if (bus.burst_read_valid) begin
        beat_cnt_q <= beats_seen;
      end
      if (len_bad || stray_beat) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr_burst_rd_master.sv
`default_nettype none
//==============================================================================
// Module      : tb_ddr_burst_rd_master
// Description : Self-checking bench for ddr_burst_rd_master (MAX_BURST=64,
//               FIFO_DEPTH=128). Contains a DDR read model returning a
//               per-address data pattern, a stream consumer, a table of
//               directed commands, hand-written corner sequences and random
//               commands checked against an arithmetic reference.
// Revision    : 1.0  initial release
//==============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 8
`endif

module tb_ddr_burst_rd_master;

  localparam int MAXB  = 64;
  localparam int DEPTH = 128;

  logic clk;
  logic rst_n;

  ddr_burst_rd_master_if #(.CNT_WIDTH(24)) bus ();

  ddr_burst_rd_master #(
    .MAX_BURST (MAXB),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (24)
  ) dut (
    .user_clk  (clk),
    .user_rst_n(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  typedef struct {
    logic [31:0] addr;
    int          beats;
    int          mode;
    bit          gaps;
    int          exp_nburst;
    int          exp_last_len;
  } vec_t;

  burst_t      bq[$];
  logic [63:0] got_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int req_cnt  = 0;
  int busy_cyc = 0;
  int req_cyc  = 0;
  int done_cyc = 0;
  int fin_cyc  = 0;
  int acc_cyc  = 0;
  int sent     = 0;
  int rdy_mode = 0;
  bit gap_en   = 1'b0;
  bit short_en = 1'b0;

  logic [31:0] m_addr;
  int          m_len;
  int          m_n;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Status monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.burst_read_req) begin
        req_cnt++;
        req_cyc = cyc;
      end
      if (bus.busy) busy_cyc++;
    end
  end

  // DDR read model: answers each request with len beats (len-1 if short_en),
  // optional gaps, then a finish pulse; aborts on reset.
  initial begin : ddr_model
    bus.burst_read_valid  = 1'b0;
    bus.burst_read_finish = 1'b0;
    bus.burst_read_data   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.burst_read_req) begin
        m_addr = bus.burst_read_addr;
        m_len  = int'(bus.burst_read_len);
        bq.push_back('{m_addr, m_len});
        sent = 0;
        m_n  = short_en ? m_len - 1 : m_len;
        if (gap_en) repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int i = 0; i < m_n; i++) begin
          if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
          if (!rst_n) break;
          bus.burst_read_valid = 1'b1;
          bus.burst_read_data  = pat(m_addr + 32'(i * 8));
          @(negedge clk);
          bus.burst_read_valid = 1'b0;
          sent++;
        end
        if (rst_n) begin
          bus.burst_read_finish = 1'b1;
          fin_cyc = cyc;
          @(negedge clk);
          bus.burst_read_finish = 1'b0;
        end
      end
    end
  end

  // Stream consumer: mode 0 never ready, 1 always ready, 2 random.
  initial begin : consumer
    bus.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_n && bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
    end
  end

  task automatic send_cmd(input logic [31:0] a, input int beats);
    for (int k = 0; k < 200 && !bus.cmd_ready; k++) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_beats = 24'(beats);
    acc_cyc       = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done_drain(input string tag, input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_in_time"}, int'(done_cnt != d0), 1);
    k = 0;
    while (bus.m_valid && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] a, input int beats,
                         input int mode, input bit gaps);
    int d0;
    bq.delete();
    got_q.delete();
    rdy_mode = mode;
    gap_en   = gaps;
    d0       = done_cnt;
    send_cmd(a, beats);
    wait_done_drain(tag, d0);
  endtask

  // Reference: bursts and stream derived from the command alone.
  task automatic check_cmd(input string tag, input logic [31:0] a, input int beats);
    int rem, off, nb, l, nbad;
    rem = beats;
    off = 0;
    nb  = 0;
    while (rem > 0) begin
      l = (rem > MAXB) ? MAXB : rem;
      if (nb < bq.size()) begin
        check({tag, "_burst_addr"}, int'(bq[nb].addr), int'(a + 32'(off * 8)));
        check({tag, "_burst_len"}, bq[nb].len, l);
      end
      nb++;
      rem -= l;
      off += l;
    end
    check({tag, "_nbursts"}, bq.size(), nb);
    check({tag, "_nbeats"}, got_q.size(), beats);
    nbad = 0;
    foreach (got_q[i]) begin
      if (i >= beats || got_q[i] != pat(a + 32'(i * 8))) nbad++;
    end
    check({tag, "_data_errors"}, nbad, 0);
  endtask

  vec_t vecs[6];

  initial begin : main
    int r0, b0, d0, k;
    vecs[0] = '{32'h0000_1000,  10, 1, 1'b0, 1, 10};
    vecs[1] = '{32'h0000_1000, 150, 1, 1'b0, 3, 22};
    vecs[2] = '{32'h0000_3000,  64, 2, 1'b1, 1, 64};
    vecs[3] = '{32'h0000_4000,  65, 2, 1'b1, 2,  1};
    vecs[4] = '{32'h0000_8000, 128, 2, 1'b0, 2, 64};
    vecs[5] = '{32'h0000_A000,   1, 1, 1'b1, 1,  1};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_beats = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy",     int'(bus.busy), 0);
    check("rst_req",      int'(bus.burst_read_req), 0);
    check("rst_addr",     int'(bus.burst_read_addr), 0);
    check("rst_len",      int'(bus.burst_read_len), 0);
    check("rst_done",     int'(bus.done), 0);
    check("rst_m_valid",  int'(bus.m_valid), 0);
    check("rst_m_data",   int'(bus.m_data != 64'd0), 0);
`ifdef DDR_RD_BEATCHK_EN
    check("rst_err",      int'(bus.err), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", int'(bus.cmd_ready), 1);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      run_cmd($sformatf("vec%0d", v), vecs[v].addr, vecs[v].beats, vecs[v].mode, vecs[v].gaps);
      check_cmd($sformatf("vec%0d", v), vecs[v].addr, vecs[v].beats);
      check($sformatf("vec%0d_tbl_nbursts", v), bq.size(), vecs[v].exp_nburst);
      if (bq.size() > 0) check($sformatf("vec%0d_tbl_last_len", v), bq[$].len, vecs[v].exp_last_len);
      if (v == 0) begin
        check("cmd_to_req_latency", req_cyc - acc_cyc, 2);
        check("finish_to_done_latency", done_cyc - fin_cyc, 1);
      end
    end

    // Stall: FIFO full after two bursts, consumer idle
    bq.delete();
    got_q.delete();
    rdy_mode = 0;
    gap_en   = 1'b0;
    r0 = req_cnt;
    d0 = done_cnt;
    send_cmd(32'h0000_5000, 200);
    k = 0;
    while (req_cnt - r0 < 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (150) @(negedge clk);
    check("stall_reqs",    req_cnt - r0, 2);
    check("stall_busy",    int'(bus.busy), 1);
    check("stall_req_low", int'(bus.burst_read_req), 0);
    check("stall_m_valid", int'(bus.m_valid), 1);
    check("stall_no_done", done_cnt - d0, 0);
    rdy_mode = 1;
    wait_done_drain("stall", d0);
    check_cmd("stall", 32'h0000_5000, 200);

    // Zero-length command
    r0 = req_cnt;
    b0 = busy_cyc;
    run_cmd("zero", 32'h0000_9000, 0, 1, 1'b0);
    check("zero_no_req", req_cnt - r0, 0);
    check("zero_busy_seen", int'((busy_cyc - b0) >= 1 && (busy_cyc - b0) <= 2), 1);
    check_cmd("zero", 32'h0000_9000, 0);

    // Reset during a burst
    bq.delete();
    got_q.delete();
    rdy_mode = 0;
    gap_en   = 1'b0;
    sent     = 0;
    send_cmd(32'h0000_6000, 64);
    k = 0;
    while (sent < 5 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("arst_beats_reached", int'(sent >= 5), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",    int'(bus.busy), 0);
    check("arst_req",     int'(bus.burst_read_req), 0);
    check("arst_addr",    int'(bus.burst_read_addr), 0);
    check("arst_len",     int'(bus.burst_read_len), 0);
    check("arst_done",    int'(bus.done), 0);
    check("arst_m_valid", int'(bus.m_valid), 0);
    check("arst_m_data",  int'(bus.m_data != 64'd0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_post_m_valid", int'(bus.m_valid), 0);
    run_cmd("post_rst", 32'h0000_2000, 4, 1, 1'b0);
    check_cmd("post_rst", 32'h0000_2000, 4);

    // Random commands
    for (int t = 0; t < 6; t++) begin
      logic [31:0] ra;
      int rb;
      ra = 32'($urandom) & 32'h00FF_FFF8;
      rb = int'($urandom_range(0, 260));
      run_cmd($sformatf("rnd%0d", t), ra, rb, 2, 1'($urandom_range(0, 1)));
      check_cmd($sformatf("rnd%0d", t), ra, rb);
    end

`ifdef DDR_RD_BEATCHK_EN
    // Short burst: 9 beats for len 10
    short_en = 1'b1;
    run_cmd("short", 32'h0000_7000, 10, 1, 1'b0);
    short_en = 1'b0;
    check("short_err_set", int'(bus.err), 1);
    check("short_nbeats", got_q.size(), 9);
    repeat (10) @(negedge clk);
    check("short_err_sticky", int'(bus.err), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
